int_ctrl: RTL and testbench
===========================

// Module: int_ctrl
// PURPOSE
//   Multi-source interrupt controller sequencing the CPU interrupt path (int_req/int_vec).
//   Latches rising edges from up to 8 sources (UART, GPIO, timer...), applies a mask,
//   picks the lowest-index pending source, and presents one request plus a computed
//   vector. Holds the source in service until software writes EOI. Registers sit in the
//   8-bit MMIO space on the CPU data-memory port (rs_data/rd_data/mem_w_en).
// PARAMETERS
//   N_SRC       4       number of interrupt sources, legal 1..8
//   VEC_SHIFT   2       vector spacing: int_vec = vbase + (id << VEC_SHIFT), mod 256
//   ADDR_MASK   8'd248  MMIO addr of MASK register (rw, 1 = enabled)
//   ADDR_PEND   8'd247  MMIO addr of PEND register (read; write-1-to-clear)
//   ADDR_VBASE  8'd246  MMIO addr of VBASE register (rw)
//   ADDR_EOI    8'd245  MMIO addr of EOI (write any = end of service; read = status)
// PORTS
//   clock     in   1      system clock
//   reset_n   in   1      asynchronous, active-low reset
//   src_i     in   N_SRC  interrupt source levels; rising edge = event
//   addr_i    in   8      CPU MMIO address (rs_data)
//   wdata_i   in   8      CPU write data (rd_data)
//   w_en_i    in   1      CPU memory write enable
//   rdata_o   out  8      read data for the addressed register, 0 when !hit_o
//   hit_o     out  1      addr_i matches one of the four registers (comb)
//   int_ack_i in   1      one-cycle pulse: CPU has taken the vector
//   int_req_o out  1      interrupt request to CPU
//   int_vec_o out  8      vector for the current request
// BEHAVIOUR
//   Reset: MASK=0, PEND=0, VBASE=0, state IDLE, id=0, int_req_o=0, int_vec_o=0, src history=0.
//   Edge detect: PEND[i] set on cycle after src(i) 0->1 sampled; set beats any clear in same cycle.
//   Register writes take effect at next clock edge; reads combinational.
//   PEND write: bits written 1 cleared (unless simultaneously set). MASK/VBASE: plain write.
//   Status read at ADDR_EOI: {state[1:0], 3'b0, id[2:0]}; PEND/MASK read zero-extended.
//   FSM:
//     IDLE    : if |(PEND & MASK) -> latch id = lowest set index, go REQ.
//     REQ     : int_req_o=1. int_ack_i -> clear PEND[id], go SERVICE.
//               PEND[id] or MASK[id] cleared by software (no ack) -> IDLE, int_req_o drops next cycle.
//     SERVICE : int_req_o=0; new events keep accumulating in PEND. EOI write -> IDLE.
//   int_req_o registered: high from the cycle after entering REQ until cycle after ack.
//   int_vec_o = VBASE + (id << VEC_SHIFT), 8-bit wrap; frozen (VBASE sampled) while REQ/SERVICE;
//     in IDLE tracks VBASE.
//   Latency (no sync): src edge sampled at t -> PEND at t+1 -> REQ/int_req_o at t+2.
//   int_ack_i outside REQ ignored; EOI outside SERVICE ignored; ack and EOI same cycle in REQ:
//     ack wins, EOI dropped. No nesting: higher-priority source waits for EOI.
//   Reset mid-REQ/SERVICE: everything returns to reset values immediately (async).
// CONFIGURATION
//   INT_CTRL_SYNC_EN defined: each src_i passes a 2-flop synchronizer (reset 0) before edge
//     detect; latency +2 cycles (int_req_o at t+4). Not defined: src_i used directly
//     (sources must be synchronous to clock).
// STRUCTURE
//   int_ctrl_defs.vh: FSM state encodings (IDLE=2'd0, REQ=2'd1, SERVICE=2'd2), default
//     register addresses, ID width (3).
//   Sub-module int_prio_enc: N_SRC-bit vector -> {valid, lowest set index}; pure combinational.
// TESTING
//   T1 reset: assert reset_n=0 mid-SERVICE -> int_req_o=0, PEND/MASK/VBASE read 0, status 0.
//   T2 basic: VBASE=8'h40, MASK=4'hF, pulse src[2] -> int_req_o at t+2, int_vec_o=8'h48;
//      ack -> PEND=0, status state=SERVICE id=2; EOI write -> IDLE.
//   T3 priority: edges on src[3] and src[1] same cycle -> vector id 1 first; after EOI
//      id 3 served (vec=VBASE+12).
//   T4 mask/withdraw: MASK=0, edge src[0] -> PEND=1, no req; MASK=1 -> req; clear PEND bit 0
//      before ack -> int_req_o drops, state IDLE.
//   T5 boundaries: VBASE=8'hFC, id=1 -> int_vec_o=8'h00 (wrap); edge on src[1] same cycle as
//      W1C of PEND[1] -> PEND[1] stays 1; ack with EOI in REQ -> SERVICE.
//   T6 INT_CTRL_SYNC_EN build: repeat T2 -> int_req_o at t+4, vector identical.

Source files
------------

// File: rtl/int_ctrl_pkg.sv
// ============================================================================
// Module      : int_ctrl_pkg
// Description : Shared types and constants for the interrupt controller:
//               FSM state encoding, default MMIO register addresses and the
//               width of the source index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package int_ctrl_pkg;

    // Width of a source index; enough for up to 8 sources.
    localparam int ID_W = 3;

    // Default MMIO addresses (top of the 8-bit data-memory space).
    localparam logic [7:0] DEF_ADDR_MASK  = 8'd248;
    localparam logic [7:0] DEF_ADDR_PEND  = 8'd247;
    localparam logic [7:0] DEF_ADDR_VBASE = 8'd246;
    localparam logic [7:0] DEF_ADDR_EOI   = 8'd245;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/int_prio_enc.sv
// ============================================================================
// Module      : int_prio_enc
// Description : Combinational priority encoder. Reports whether any bit of
//               the input vector is set and the index of the lowest set bit.
// Revision    : 1.0 - initial release
// Ports       : vec   in  N      request vector
//               valid out 1      at least one bit set
//               idx   out IDX_W  lowest set index (0 when !valid)
// ============================================================================
`default_nettype none

module int_prio_enc #(
    parameter int N     = 4,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     vec,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        valid = |vec;
        idx   = '0;
        // Scan downward so the lowest set bit is the last one to assign.
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/int_ctrl.sv
// ============================================================================
// Module      : int_ctrl
// Description : Multi-source interrupt controller. Latches rising edges of
//               the sources into PEND, masks them with MASK, requests the
//               lowest-index pending source with vector VBASE+(id<<VEC_SHIFT)
//               and holds it in service until software writes EOI.
// Revision    : 1.0 - initial release
// Config      : INT_CTRL_SYNC_EN - when defined, every source passes through
//               a 2-flop synchronizer before edge detection (+2 cycles).
// Ports       : clock, reset_n        clock / async active-low reset
//               src_i     in  N_SRC   source levels, rising edge = event
//               addr_i    in  8       MMIO address
//               wdata_i   in  8       MMIO write data
//               w_en_i    in  1       MMIO write enable
//               rdata_o   out 8       read data (0 when no register hit)
//               hit_o     out 1       addr_i selects a controller register
//               int_ack_i in  1       CPU has taken the vector
//               int_req_o out 1       interrupt request
//               int_vec_o out 8       vector of the current request
// ============================================================================
`default_nettype none

module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int         N_SRC      = 4,
    parameter int         VEC_SHIFT  = 2,
    parameter logic [7:0] ADDR_MASK  = DEF_ADDR_MASK,
    parameter logic [7:0] ADDR_PEND  = DEF_ADDR_PEND,
    parameter logic [7:0] ADDR_VBASE = DEF_ADDR_VBASE,
    parameter logic [7:0] ADDR_EOI   = DEF_ADDR_EOI
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [N_SRC-1:0] src_i,
    input  logic [7:0]       addr_i,
    input  logic [7:0]       wdata_i,
    input  logic             w_en_i,
    output logic [7:0]       rdata_o,
    output logic             hit_o,
    input  logic             int_ack_i,
    output logic             int_req_o,
    output logic [7:0]       int_vec_o
);

    state_t            state, state_nxt;
    logic [N_SRC-1:0]  src_s, src_hist, src_rise;
    logic [N_SRC-1:0]  pend, mask, clr, id_oh;
    logic [7:0]        vbase, vbase_frz, vec_base, vec_off;
    logic [ID_W-1:0]   id, prio_id;
    logic              prio_valid, ack_clr;
    logic              sel_mask, sel_pend, sel_vbase, sel_eoi;
    logic [7:0]        pend_ext, mask_ext;

`ifdef INT_CTRL_SYNC_EN
    logic [N_SRC-1:0]  sync1, sync2;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= src_i;
            sync2 <= sync1;
        end
    end

    assign src_s = sync2;
`else
    assign src_s = src_i;
`endif

    assign src_rise = src_s & ~src_hist;

    // Register decode
    assign sel_mask  = (addr_i == ADDR_MASK);
    assign sel_pend  = (addr_i == ADDR_PEND);
    assign sel_vbase = (addr_i == ADDR_VBASE);
    assign sel_eoi   = (addr_i == ADDR_EOI);
    assign hit_o     = sel_mask | sel_pend | sel_vbase | sel_eoi;

    int_prio_enc #(
        .N     (N_SRC),
        .IDX_W (ID_W)
    ) u_prio (
        .vec   (pend & mask),
        .valid (prio_valid),
        .idx   (prio_id)
    );

    // One-hot of the in-service id, avoids indexing with a wider index.
    always_comb begin
        id_oh = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (id == ID_W'(i)) begin
                id_oh[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ack_clr   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (prio_valid) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                // Ack takes precedence over withdrawal and over a same-cycle EOI.
                if (int_ack_i) begin
                    state_nxt = ST_SERVICE;
                    ack_clr   = 1'b1;
                end else if (!(|(pend & id_oh)) || !(|(mask & id_oh))) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (w_en_i && sel_eoi) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // New edges win over software W1C and over the ack clear.
    assign clr = ((w_en_i && sel_pend) ? wdata_i[N_SRC-1:0] : '0)
               | (ack_clr ? id_oh : '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            src_hist  <= '0;
            pend      <= '0;
            mask      <= '0;
            vbase     <= '0;
            vbase_frz <= '0;
            id        <= '0;
            int_req_o <= 1'b0;
        end else begin
            state     <= state_nxt;
            src_hist  <= src_s;
            pend      <= (pend & ~clr) | src_rise;
            int_req_o <= (state_nxt == ST_REQ);
            if (state == ST_IDLE && prio_valid) begin
                id        <= prio_id;
                vbase_frz <= vbase;
            end
            if (w_en_i && sel_mask) begin
                mask <= wdata_i[N_SRC-1:0];
            end
            if (w_en_i && sel_vbase) begin
                vbase <= wdata_i;
            end
        end
    end

    // Vector follows VBASE while idle, frozen to the sampled base otherwise.
    assign vec_base  = (state == ST_IDLE) ? vbase : vbase_frz;
    assign vec_off   = {{(8 - ID_W){1'b0}}, id} << VEC_SHIFT;
    assign int_vec_o = vec_base + vec_off;

    always_comb begin
        pend_ext              = '0;
        pend_ext[N_SRC-1:0]   = pend;
        mask_ext              = '0;
        mask_ext[N_SRC-1:0]   = mask;
    end

    always_comb begin
        rdata_o = 8'h00;
        if (sel_mask) begin
            rdata_o = mask_ext;
        end else if (sel_pend) begin
            rdata_o = pend_ext;
        end else if (sel_vbase) begin
            rdata_o = vbase;
        end else if (sel_eoi) begin
            rdata_o = {state, 3'b000, id};
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_int_ctrl.sv
// ============================================================================
// Module      : tb_int_ctrl
// Description : Directed self-checking bench for int_ctrl (default and
//               INT_CTRL_SYNC_EN builds).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_int_ctrl;

    localparam logic [7:0] A_MASK  = 8'd248;
    localparam logic [7:0] A_PEND  = 8'd247;
    localparam logic [7:0] A_VBASE = 8'd246;
    localparam logic [7:0] A_EOI   = 8'd245;
    localparam logic [7:0] A_NONE  = 8'd16;

`ifdef INT_CTRL_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] src_i = '0;
    logic [7:0] addr_i = A_NONE;
    logic [7:0] wdata_i = '0;
    logic       w_en_i = 1'b0;
    logic [7:0] rdata_o;
    logic       hit_o;
    logic       int_ack_i = 1'b0;
    logic       int_req_o;
    logic [7:0] int_vec_o;

    int n_tests = 0;
    int n_fail  = 0;
    int edges;
    logic [7:0] rd;

    int_ctrl dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .src_i     (src_i),
        .addr_i    (addr_i),
        .wdata_i   (wdata_i),
        .w_en_i    (w_en_i),
        .rdata_o   (rdata_o),
        .hit_o     (hit_o),
        .int_ack_i (int_ack_i),
        .int_req_o (int_req_o),
        .int_vec_o (int_vec_o)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic mmio_wr(input logic [7:0] a, input logic [7:0] d);
        addr_i  = a;
        wdata_i = d;
        w_en_i  = 1'b1;
        tick();
        w_en_i  = 1'b0;
        addr_i  = A_NONE;
    endtask

    task automatic mmio_rd(input logic [7:0] a, output logic [7:0] d);
        addr_i = a;
        #1;
        d      = rdata_o;
        addr_i = A_NONE;
    endtask

    task automatic ack();
        int_ack_i = 1'b1;
        tick();
        int_ack_i = 1'b0;
    endtask

    // Counts edges until int_req_o rises, bounded.
    task automatic wait_req(input string tag, output int n);
        n = 0;
        while (!int_req_o && n < 20) begin
            tick();
            n++;
        end
        check(tag, {31'd0, int_req_o}, 32'd1);
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_req", {31'd0, int_req_o}, 32'd0);
        check("rst_vec", {24'd0, int_vec_o}, 32'h00);
        reset_n = 1'b1;
        #10;
        tick();
        mmio_rd(A_MASK, rd);  check("rst_mask", {24'd0, rd}, 32'h00);
        mmio_rd(A_EOI, rd);   check("rst_status", {24'd0, rd}, 32'h00);
        mmio_rd(A_NONE, rd);  check("miss_rdata", {24'd0, rd}, 32'h00);
        check("miss_hit", {31'd0, hit_o}, 32'd0);

        // T2 basic request / ack / EOI
        mmio_wr(A_VBASE, 8'h40);
        mmio_wr(A_MASK, 8'h0F);
        src_i = 4'b0100;
        wait_req("t2_req", edges);
        check("t2_latency", edges, LAT);
        check("t2_vec", {24'd0, int_vec_o}, 32'h48);
        ack();
        src_i = 4'b0000;
        check("t2_req_drop", {31'd0, int_req_o}, 32'd0);
        mmio_rd(A_PEND, rd);  check("t2_pend", {24'd0, rd}, 32'h00);
        mmio_rd(A_EOI, rd);   check("t2_status_svc", {24'd0, rd}, 32'h82);
        mmio_wr(A_EOI, 8'h00);
        mmio_rd(A_EOI, rd);   check("t2_status_idle", {24'd0, rd}, 32'h02);

        // T3 priority between simultaneous edges
        src_i = 4'b1010;
        wait_req("t3_req1", edges);
        check("t3_vec1", {24'd0, int_vec_o}, 32'h44);
        mmio_rd(A_EOI, rd);   check("t3_status_req", {24'd0, rd}, 32'h41);
        ack();
        src_i = 4'b0000;
        mmio_rd(A_PEND, rd);  check("t3_pend_left", {24'd0, rd}, 32'h08);
        tick();
        check("t3_no_nest", {31'd0, int_req_o}, 32'd0);
        mmio_wr(A_EOI, 8'h00);
        wait_req("t3_req2", edges);
        check("t3_vec2", {24'd0, int_vec_o}, 32'h4C);
        ack();
        mmio_wr(A_EOI, 8'h00);

        // T4 masking and withdrawal
        mmio_wr(A_MASK, 8'h00);
        src_i = 4'b0001;
        repeat (LAT + 1) tick();
        mmio_rd(A_PEND, rd);  check("t4_pend_masked", {24'd0, rd}, 32'h01);
        check("t4_no_req", {31'd0, int_req_o}, 32'd0);
        mmio_wr(A_MASK, 8'h01);
        wait_req("t4_req", edges);
        check("t4_vec", {24'd0, int_vec_o}, 32'h40);
        mmio_wr(A_PEND, 8'h01);
        check("t4_req_hold", {31'd0, int_req_o}, 32'd1);
        tick();
        check("t4_withdrawn", {31'd0, int_req_o}, 32'd0);
        mmio_rd(A_EOI, rd);   check("t4_status", {24'd0, rd}, 32'h00);

        // T5 boundaries
        mmio_wr(A_VBASE, 8'hFC);
        mmio_wr(A_MASK, 8'h0F);
        src_i = 4'b0010;
        wait_req("t5_req", edges);
        check("t5_vec_wrap", {24'd0, int_vec_o}, 32'h00);
        mmio_wr(A_VBASE, 8'h10);
        check("t5_vec_frozen", {24'd0, int_vec_o}, 32'h00);
        int_ack_i = 1'b1;
        addr_i    = A_EOI;
        w_en_i    = 1'b1;
        tick();
        int_ack_i = 1'b0;
        w_en_i    = 1'b0;
        addr_i    = A_NONE;
        mmio_rd(A_EOI, rd);   check("t5_ack_beats_eoi", {24'd0, rd}, 32'h81);
        mmio_wr(A_EOI, 8'h00);
        mmio_rd(A_EOI, rd);   check("t5_status_idle", {24'd0, rd}, 32'h01);
        check("t5_vec_tracks", {24'd0, int_vec_o}, 32'h14);
        mmio_wr(A_MASK, 8'h00);
        src_i = 4'b0000;
        tick();
        src_i = 4'b0010;
        repeat (LAT - 2) tick();
        mmio_wr(A_PEND, 8'h02);
        mmio_rd(A_PEND, rd);  check("t5_set_beats_clr", {24'd0, rd}, 32'h02);
        mmio_wr(A_PEND, 8'h02);
        mmio_rd(A_PEND, rd);  check("t5_w1c", {24'd0, rd}, 32'h00);

        // T1 async reset in SERVICE
        mmio_wr(A_MASK, 8'h0F);
        src_i = 4'b1000;
        wait_req("t1_req", edges);
        ack();
        mmio_rd(A_EOI, rd);   check("t1_status_svc", {24'd0, rd}, 32'h83);
        src_i = 4'b1001;
        repeat (LAT) tick();
        mmio_rd(A_PEND, rd);  check("t1_pend_accum", {24'd0, rd}, 32'h01);
        src_i = 4'b0000;
        #2;
        reset_n = 1'b0;
        #1;
        check("t1_req", {31'd0, int_req_o}, 32'd0);
        check("t1_vec", {24'd0, int_vec_o}, 32'h00);
        mmio_rd(A_PEND, rd);  check("t1_pend", {24'd0, rd}, 32'h00);
        mmio_rd(A_MASK, rd);  check("t1_mask", {24'd0, rd}, 32'h00);
        mmio_rd(A_VBASE, rd); check("t1_vbase", {24'd0, rd}, 32'h00);
        mmio_rd(A_EOI, rd);   check("t1_status", {24'd0, rd}, 32'h00);
        reset_n = 1'b1;
        repeat (3) tick();
        check("t1_idle_after", {31'd0, int_req_o}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
